// File: rtl/mem_bist_ctrl_if.sv
// Memory-side port between the BIST sequencer and the 32x8 synchronous memory.
// The master (sequencer) drives the strobes, address and write data; the
// slave (memory) returns read data one cycle after a read strobe.
interface mem_bist_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output read, output write, output addr, output data_in, input data_out);
    modport slave  (input read, input write, input addr, input data_in, output data_out);
endinterface

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST sequencer: write pattern, read/compare, write the
// inverted pattern, read/compare, over every address. Reports busy/done/pass,
// a saturating mismatch count and the first failing address/phase/data.
// Every output is registered; the registered outputs are decoded from the
// next state so they line up with the state they describe.
module mem_bist_ctrl #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    mem_bist_ctrl_if.master     mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_count,
    output logic [ADDR_W-1:0]   first_fail_addr,
    output logic                first_fail_phase,
    output logic [DATA_W-1:0]   first_fail_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE, W0, R0_ISS, R0_CMP, W1, R1_ISS, R1_CMP, DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W+1:0] err_n;
    logic [ADDR_W-1:0] ffa_n;
    logic              ffp_n;
    logic [DATA_W-1:0] ffd_n;
    logic              rd_n, wr_n, busy_n, done_n, pass_n;
    logic [DATA_W-1:0] wdata_n;

    // Expected memory contents: pattern XOR address, inverted in the second half.
    function automatic logic [DATA_W-1:0] expected(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] e;
        e = PATTERN ^ DATA_W'(a);
        return inv ? ~e : e;
    endfunction

    // Error count saturates instead of wrapping.
    function automatic logic [ADDR_W+1:0] sat_inc(input logic [ADDR_W+1:0] v);
        return (v == '1) ? v : v + (ADDR_W+2)'(1);
    endfunction

    // State and address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, compare/capture and next-output decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err_count;
        ffa_n   = first_fail_addr;
        ffp_n   = first_fail_phase;
        ffd_n   = first_fail_data;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = W0;
                    cnt_n   = '0;
                    err_n   = '0;
                    ffa_n   = '0;
                    ffp_n   = 1'b0;
                    ffd_n   = '0;
                end
            end
            W0, W1: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST_ADDR) begin
                    state_n = (state == W0) ? R0_ISS : R1_ISS;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            R0_ISS, R1_ISS: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    state_n = (state == R0_ISS) ? R0_CMP : R1_CMP;
                end
            end
            R0_CMP, R1_CMP: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    if (mem.data_out != expected(cnt, state == R1_CMP)) begin
                        err_n = sat_inc(err_count);
                        if (err_count == '0) begin
                            ffa_n = cnt;
                            ffp_n = (state == R1_CMP);
                            ffd_n = mem.data_out;
                        end
                    end
                    if (cnt != LAST_ADDR) begin
                        cnt_n   = cnt + ADDR_W'(1);
                        state_n = (state == R0_CMP) ? R0_ISS : R1_ISS;
                    end else begin
                        cnt_n   = '0;
                        state_n = (state == R0_CMP) ? W1 : DONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        wr_n    = (state_n == W0) || (state_n == W1);
        rd_n    = (state_n == R0_ISS) || (state_n == R1_ISS);
        wdata_n = wr_n ? expected(cnt_n, state_n == W1) : '0;
        busy_n  = (state_n != IDLE) && (state_n != DONE);
        done_n  = (state_n == DONE);
        pass_n  = done_n && (err_n == '0);
    end

    // Registered memory port, status and failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.read         <= 1'b0;
            mem.write        <= 1'b0;
            mem.addr         <= '0;
            mem.data_in      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
            first_fail_data  <= '0;
        end else begin
            mem.read         <= rd_n;
            mem.write        <= wr_n;
            mem.addr         <= cnt_n;
            mem.data_in      <= wdata_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
            err_count        <= err_n;
            first_fail_addr  <= ffa_n;
            first_fail_phase <= ffp_n;
            first_fail_data  <= ffd_n;
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a behavioural 32x8 memory with a configurable
// read fault, a table of fault scenarios with hand-computed results, and
// hand-written sequences for abort, asynchronous reset and start spam.
module tb_mem_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort;
    logic       busy, done, pass;
    logic [6:0] err_count;
    logic [4:0] first_fail_addr;
    logic       first_fail_phase;
    logic [7:0] first_fail_data;

    mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) mif ();

    mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .PATTERN(8'hA5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .mem              (mif),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_addr  (first_fail_addr),
        .first_fail_phase (first_fail_phase),
        .first_fail_data  (first_fail_data)
    );

    // Memory model with optional read fault (AND/OR masks on one or all addresses)
    logic [7:0] mem_arr [32];
    logic [7:0] rd_q = 8'h00;
    bit         f_en = 1'b0;
    bit         f_all = 1'b0;
    int         f_addr = 0;
    logic [7:0] f_and = 8'hFF;
    logic [7:0] f_or = 8'h00;

    always @(posedge clk) begin
        if (mif.write) mem_arr[mif.addr] <= mif.data_in;
        if (mif.read) begin
            if (f_en && (f_all || int'(mif.addr) == f_addr))
                rd_q <= (mem_arr[mif.addr] & f_and) | f_or;
            else
                rd_q <= mem_arr[mif.addr];
        end
    end
    assign mif.data_out = rd_q;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int a, input bit inv);
        logic [7:0] e;
        e = 8'hA5 ^ 8'(a);
        return inv ? ~e : e;
    endfunction

    // Expected memory-port activity for busy cycle c (0..191)
    function automatic bit cycle_ok(input int c);
        bit ok;
        bit erd, ewr;
        int ea;
        logic [7:0] ed;
        erd = 0; ewr = 0; ea = 0; ed = 8'h00;
        if (c < 32) begin
            ewr = 1; ea = c; ed = exp_data(c, 0);
        end else if (c < 96) begin
            erd = ((c - 32) % 2 == 0); ea = (c - 32) / 2;
        end else if (c < 128) begin
            ewr = 1; ea = c - 96; ed = exp_data(c - 96, 1);
        end else begin
            erd = ((c - 128) % 2 == 0); ea = (c - 128) / 2;
        end
        ok = (mif.read === erd) && (mif.write === ewr) && (done === 1'b0) && (pass === 1'b0);
        if (ewr) ok = ok && (mif.addr === 5'(ea)) && (mif.data_in === ed);
        if (erd) ok = ok && (mif.addr === 5'(ea));
        return ok;
    endfunction

    // Pulse start and follow the run until busy drops (bounded)
    task automatic run_bist(input bit spam, output int cyc, output int seq_bad, output int both);
        cyc = 0; seq_bad = 0; both = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (busy === 1'b1 && cyc < 300) begin
            if (!cycle_ok(cyc)) seq_bad++;
            if (mif.read && mif.write) both++;
            if (spam) start = 1'($urandom_range(0, 1));
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (mif.read && mif.write) both++;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, pass, err_count, first_fail_addr, first_fail_phase,
                     first_fail_data, mif.read, mif.write, mif.addr, mif.data_in}, 64'h0);
    endtask

    typedef struct {
        string      name;
        bit         en;
        bit         all;
        int         addr;
        logic [7:0] and_m;
        logic [7:0] or_m;
        int         e_err;
        bit         e_pass;
        int         e_ffa;
        bit         e_ffp;
        logic [7:0] e_ffd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cyc, seq_bad, both;

        vecs[0] = '{"clean",        0, 0,  0, 8'hFF, 8'h00,  0, 1,  0, 0, 8'h00};
        vecs[1] = '{"a7_bit0_hi",   1, 0,  7, 8'hFF, 8'h01,  1, 0,  7, 0, 8'hA3};
        vecs[2] = '{"a3_zero",      1, 0,  3, 8'h00, 8'h00,  2, 0,  3, 0, 8'h00};
        vecs[3] = '{"a31_bit0_lo",  1, 0, 31, 8'hFE, 8'h00,  1, 0, 31, 1, 8'h44};
        vecs[4] = '{"all_zero",     1, 1,  0, 8'h00, 8'h00, 64, 0,  0, 0, 8'h00};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        #12;
        check_all_zero("reset_outputs");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_busy", {busy, done}, 0);

        // Fault scenarios from the table
        for (int i = 0; i < 5; i++) begin
            f_en = vecs[i].en; f_all = vecs[i].all; f_addr = vecs[i].addr;
            f_and = vecs[i].and_m; f_or = vecs[i].or_m;
            run_bist(1'b0, cyc, seq_bad, both);
            check({vecs[i].name, "_busy_len"}, cyc, 192);
            check({vecs[i].name, "_sequence"}, seq_bad, 0);
            check({vecs[i].name, "_rw_both"}, both, 0);
            check({vecs[i].name, "_done"}, {busy, done}, 2'b01);
            check({vecs[i].name, "_pass"}, pass, vecs[i].e_pass);
            check({vecs[i].name, "_err_count"}, err_count, vecs[i].e_err);
            check({vecs[i].name, "_ff_addr"}, first_fail_addr, vecs[i].e_ffa);
            check({vecs[i].name, "_ff_phase"}, first_fail_phase, vecs[i].e_ffp);
            check({vecs[i].name, "_ff_data"}, first_fail_data, vecs[i].e_ffd);
            check({vecs[i].name, "_port_idle"}, {mif.read, mif.write}, 0);
        end

        // Done holds across idle cycles; abort in DONE has no effect
        f_en = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_done", {busy, done, pass, err_count}, {3'b010, 7'd64});

        // Abort 50 cycles into a run (R0 phase)
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("abort_run_started", {busy, done, err_count}, {2'b10, 7'd0});
        repeat (50) @(negedge clk);
        check("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_stops", {busy, done, pass, mif.read, mif.write}, 5'b0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {busy, done}, 2'b0);

        // A fresh run after abort completes normally
        run_bist(1'b0, cyc, seq_bad, both);
        check("post_abort_len", cyc, 192);
        check("post_abort_seq", seq_bad, 0);
        check("post_abort_result", {done, pass, err_count}, {2'b11, 7'd0});

        // Asynchronous reset in the middle of W1
        f_en = 1'b1; f_all = 1'b1; f_and = 8'h00; f_or = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        check("w1_midrun", {busy, mif.write, mif.read, err_count}, {3'b110, 7'd32});
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("idle_after_reset");

        // Start hammered while busy must not disturb the sequence
        f_en = 1'b0;
        run_bist(1'b1, cyc, seq_bad, both);
        check("spam_len", cyc, 192);
        check("spam_seq", seq_bad, 0);
        check("spam_rw_both", both, 0);
        check("spam_result", {done, pass, err_count}, {2'b11, 7'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Built-in self-test sequencer that sits directly upstream of the 32x8 synchronous memory and drives its read/write/addr/data_in port in place of the testbench tasks. On start it runs a four-phase march over every address: write pattern, read and compare, write inverted pattern, read and compare. It reports busy/done/pass plus an error count and first-failure capture. Status outputs feed a CPU-visible status register block.

Parameters:
ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W
DATA_W, 8, memory data width
PATTERN, 8'hA5, base data pattern (DATA_W bits)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin test; sampled only in IDLE/DONE
abort  input  1  terminate a running test
read  output  1  memory read strobe
write  output  1  memory write strobe
addr  output  ADDR_W  memory address
data_in  output  DATA_W  write data to memory
data_out  input  DATA_W  read data from memory
busy  output  1  test in progress
done  output  1  test completed (held until next start)
pass  output  1  done and zero errors
err_count  output  ADDR_W+2  total mismatches (max 2*DEPTH = 64, never wraps)
first_fail_addr  output  ADDR_W  address of first mismatch
first_fail_phase  output  1  0 = true-pattern read, 1 = inverted read
first_fail_data  output  DATA_W  data_out captured at first mismatch

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low. All outputs registered.
- Reset value of every output: 0. On reset the FSM enters IDLE, the address counter clears and all capture registers clear, including mid-test.
- Memory contract: a write occurs on the rising edge when write=1. A read is requested on the rising edge when read=1. data_out is valid throughout the following cycle, so the block samples it one cycle after the read cycle.
- Expected data: exp(a) = PATTERN ^ zero-extended a in phases W0/R0, and ~exp(a) in phases W1/R1.
- States: IDLE, W0, R0_ISS, R0_CMP, W1, R1_ISS, R1_CMP, DONE.
- IDLE/DONE + start=1: clear err_count and first_fail_*, clear done/pass, set busy, set cnt=0, go to W0.
- W0/W1: write=1, read=0, addr=cnt, data_in=exp/~exp.
  - One address per cycle; write stays high across consecutive addresses.
  - At cnt==DEPTH-1, go to R0_ISS/R1_ISS with cnt=0; write deasserts.
- Rx_ISS: read=1, write=0, addr=cnt for exactly one cycle, then Rx_CMP.
- Rx_CMP: read=0; compare data_out against the expected value.
  - On mismatch: err_count+1; if this is the first error, capture cnt, phase and data_out.
  - If cnt<DEPTH-1: cnt+1, back to Rx_ISS. Otherwise R0 goes to W1 (cnt=0) and R1 goes to DONE.
- Length: each read costs 2 cycles. busy is high for exactly 2*DEPTH + 4*DEPTH = 192 cycles, starting the cycle after start is sampled.
- DONE: busy=0, done=1, pass=(err_count==0), read=write=0. Hold until start or reset.
- start while busy: ignored, with no effect on sequencing.
- abort while busy (takes priority over an advance): next cycle IDLE, busy=0, read=write=0, done=0, pass=0. err_count and first_fail_* keep their partial values. abort in IDLE/DONE: no effect.
- start and abort in the same cycle while in IDLE/DONE: start wins.
- Never assert read and write in the same cycle.

Test Plan:
- Fault-free memory model, start pulse: busy high for exactly 192 cycles. Write/read order is 0..31 per phase, with data_in A5,A4,A7,... in W0 and 5A,5B,... in W1. Then done=1, pass=1, err_count=0.
- Bit0 of addr 7 stuck at 1: R0 sees A3 vs expected A2, R1 matches 5D. Result: done=1, pass=0, err_count=1, first_fail_addr=7, first_fail_phase=0, first_fail_data=A3.
- Addr 3 returns 8'h00 always: err_count=2; first capture is addr 3, phase 0, data 00; pass=0.
- abort asserted 50 cycles after start (in R0): next cycle busy=0, done=0, read=write=0. A new start then runs the full 192 cycles and clears counters.
- rst_n low mid-W1: all outputs 0 immediately, without waiting for clk. Release reset; the block stays in IDLE until start.
- start pulsed repeatedly while busy: sequence unchanged, still 192 cycles. Also confirm read&write are never both 1 across every run.
